// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; one bit per cycle, then a sign-fix cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand magnitudes and signs at issue
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg  = op[0] & src_a[WIDTH-1];
    b_neg  = op[0] & src_b[WIDTH-1];
    b_zero = (src_b == '0);
    a_mag  = a_neg ? -src_a : src_a;
    b_mag  = b_neg ? -src_b : src_b;
  end

  // One shift-add multiply step: accumulator holds {partial product, remaining multiplier}
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  always_comb begin
    mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                        : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // One restoring divide step on {remainder, quotient}; extra top bit catches the borrow
  logic [WIDTH+1:0]     div_trial;
  logic [2*WIDTH-1:0]   div_next;

  always_comb begin
    div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
    if (div_trial[WIDTH+1]) begin
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction applied in the fix cycle
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot, rem, quot_fix, rem_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot     = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    quot_fix = (neg_q && !b_zero_q) ? -quot : quot;
    rem_fix  = (rem_neg_q && !b_zero_q) ? -rem : rem;
    fix_hi   = is_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = is_div_q ? quot_fix : prod_fix[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    b_zero_d  = b_zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_div_d  = op[1];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          b_zero_d  = b_zero;
          cnt_d     = '0;
          state_d   = StRun;
          if (op[1]) begin
            // Divide by zero keeps the raw dividend so the remainder comes out as src_a
            acc_d  = {{WIDTH{1'b0}}, (b_zero ? src_a : a_mag)};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end else begin
          if (we_hi) hi_d = wd;
          if (we_lo) lo_d = wd;
        end
      end
      StRun: begin
        if (cancel) begin
          state_d = StIdle;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!cancel) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      b_zero_q  <= b_zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == StRun) || (state_q == StFix);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] wd;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .we_hi  (we_hi),
    .we_lo  (we_lo),
    .wd     (wd),
    .cancel (cancel),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles until idle (bounded), returns the count
  task automatic wait_idle(output int unsigned n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_hi,
                        input logic [WIDTH-1:0] exp_lo);
    int unsigned n;
    issue(o, a, b);
    wait_idle(n);
    check_eq({tag, "_busy_cycles"}, 64'(n), 64'd33);
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    tick();
    check_eq({tag, "_done_clear"}, 64'(done), 64'd0);
  endtask

  initial begin
    int unsigned n;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    src_a  = '0;
    src_b  = '0;
    we_hi  = 1'b0;
    we_lo  = 1'b0;
    wd     = '0;
    cancel = 1'b0;
    tick();
    tick();
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("mult_neg",    2'b01, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu_100_7",  2'b10, 32'd100,       32'd7,        32'd2,         32'd14);
    run_op("div_m7_2",    2'b11, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_by0",    2'b10, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF);
    run_op("div_ovf",     2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
    run_op("div_by0_neg", 2'b11, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("mult_pos",    2'b01, 32'd6,         32'd7,        32'd0,         32'd42);

    // Restart attempt and MTHI during busy: only the first op's result lands
    issue(2'b00, 32'd1000, 32'd1000);
    for (int i = 0; i < 5; i++) tick();
    op    = 2'b10;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    we_hi = 1'b1;
    wd    = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    we_hi = 1'b0;
    src_a = 32'd9;
    wait_idle(n);
    check_eq("restart_busy_cycles", 64'(n + 6), 64'd33);
    check_eq("restart_hi", 64'(hi), 64'd0);
    check_eq("restart_lo", 64'(lo), 64'd1000000);
    tick();

    // MTLO in idle
    we_lo = 1'b1;
    wd    = 32'h1234;
    tick();
    we_lo = 1'b0;
    check_eq("mtlo_lo", 64'(lo), 64'h1234);
    check_eq("mtlo_hi", 64'(hi), 64'd0);
    check_eq("mtlo_done", 64'(done), 64'd0);
    check_eq("mtlo_busy", 64'(busy), 64'd0);

    // MTHI and MTLO together
    we_hi = 1'b1;
    we_lo = 1'b1;
    wd    = 32'hCAFE_0001;
    tick();
    we_hi = 1'b0;
    we_lo = 1'b0;
    check_eq("mt_both_hi", 64'(hi), 64'hCAFE_0001);
    check_eq("mt_both_lo", 64'(lo), 64'hCAFE_0001);

    // start beats a simultaneous MTLO
    we_lo = 1'b1;
    wd    = 32'h5555_5555;
    issue(2'b10, 32'd100, 32'd7);
    we_lo = 1'b0;
    wait_idle(n);
    check_eq("start_prio_lo", 64'(lo), 64'd14);
    check_eq("start_prio_hi", 64'(hi), 64'd2);
    tick();

    // Cancel at RUN cycle 10
    issue(2'b00, 32'd3, 32'd3);
    for (int i = 0; i < 10; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check_eq("cancel_busy", 64'(busy), 64'd0);
    check_eq("cancel_done", 64'(done), 64'd0);
    check_eq("cancel_hi", 64'(hi), 64'd2);
    check_eq("cancel_lo", 64'(lo), 64'd14);
    tick();
    check_eq("cancel_done_later", 64'(done), 64'd0);
    check_eq("cancel_lo_later", 64'(lo), 64'd14);

    // Asynchronous reset mid-RUN
    issue(2'b01, 32'd5, 32'd5);
    tick();
    tick();
    check_eq("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", 64'(busy), 64'd0);
    check_eq("async_rst_hi", 64'(hi), 64'd0);
    check_eq("async_rst_lo", 64'(lo), 64'd0);
    check_eq("async_rst_done", 64'(done), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("post_rst", 2'b10, 32'd50, 32'd6, 32'd2, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
